// File: rtl/rr_arb_mux.sv
// N-channel arbitrating mux with a registered output stage.
// Round-robin or fixed-priority grant, one word per cycle.
module rr_arb_mux #(
   parameter int N    = 8,
   parameter int W    = 8,
   parameter int MODE = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N*W-1:0]       in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   output logic [W-1:0]         out_data,
   output logic [$clog2(N)-1:0] out_sel,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int SW = $clog2(N);

   logic [SW-1:0] last;
   logic [SW-1:0] gnt;
   logic [W-1:0]  gnt_data;
   logic          found;
   logic          ld;

   assign ld = !out_valid || out_ready;

   // Pass one takes channels above last; pass two wraps to the rest.
   always_comb begin
      found    = 1'b0;
      gnt      = '0;
      gnt_data = '0;
      for (int i = 0; i < N; i++) begin
         if (!found && in_valid[i] &&
             (MODE == 1 || SW'(i) > last)) begin
            found    = 1'b1;
            gnt      = SW'(i);
            gnt_data = in_data[i*W +: W];
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && in_valid[i]) begin
            found    = 1'b1;
            gnt      = SW'(i);
            gnt_data = in_data[i*W +: W];
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (ld && found && !rst)
         in_ready = N'(1) << gnt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         last      <= SW'(N - 1);
      end else if (ld) begin
         if (found) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_sel   <= gnt;
            if (MODE == 0)
               last <= gnt;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 The block SHALL have parameter N, default 8: number of input channels, legal range 2..64.
REQ-002 The block SHALL have parameter W, default 8: data width per channel, minimum 1.
REQ-003 The block SHALL have parameter MODE, default 0: arbitration policy, 0 = round-robin, 1 = fixed priority with lowest index winning.
REQ-004 The block SHALL derive localparam SW = $clog2(N), the select width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port in_data, input, N*W bits: channel i occupies in_data[i*W +: W].
REQ-008 The block SHALL have port in_valid, input, N bits: per-channel request.
REQ-009 The block SHALL have port in_ready, output, N bits: per-channel accept, one-hot or zero.
REQ-010 The block SHALL have port out_data, output, W bits: registered selected data.
REQ-011 The block SHALL have port out_sel, output, SW bits: registered index of the channel that sourced out_data.
REQ-012 The block SHALL have port out_valid, output, 1 bit: output register holds a word.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accept.

Function
REQ-014 The block SHALL define the load enable as ld = !out_valid || out_ready.
REQ-015 When ld=1 and in_valid is non-zero, the block SHALL pick exactly one grant index g, drive in_ready = (1<<g) combinationally, and on the next edge load out_data = channel g data, out_sel = g and out_valid = 1; an input transfer occurs when in_valid[g] && in_ready[g].
REQ-016 When ld=1 and in_valid = 0, the block SHALL drive in_ready = 0 and load out_valid = 0 on the next edge, leaving out_data and out_sel unchanged.
REQ-017 When ld=0 (out_valid=1, out_ready=0), the block SHALL drive in_ready = 0 and hold out_data, out_sel and out_valid stable; no grant occurs.
REQ-018 With MODE=0, the block SHALL keep a pointer last (SW bits); the search SHALL start at last+1, wrap from N-1 to 0 (including non-power-of-two N), and choose the first channel with in_valid set.
REQ-019 With MODE=0, last SHALL update to g only on an input transfer and SHALL be unchanged otherwise.
REQ-020 With MODE=1, g SHALL be the lowest index with in_valid set, and last SHALL remain unused at its reset value.
REQ-021 Input-to-output latency SHALL be 1 cycle, and throughput SHALL be 1 word per cycle while out_ready=1.
REQ-022 in_ready SHALL depend only on in_valid, out_valid, out_ready and last; in_valid SHALL NOT be required to wait for in_ready.
REQ-023 A channel that drops in_valid before being granted SHALL simply be skipped, with no state retained for it.
REQ-024 When only the channel at index last requests (MODE=0), it SHALL be granted after the search wraps fully.

Reset
REQ-025 While rst=1, the block SHALL immediately force out_valid=0, out_data=0 and out_sel=0, independent of clk.
REQ-026 While rst=1, the block SHALL force last=N-1, so the first round-robin search starts at channel 0, and SHALL hold in_ready=0.
REQ-027 Reset asserted mid-stream SHALL discard the held word, and the first grant after release SHALL follow REQ-026.

Verification
REQ-028 Reset: with N=8, W=8, assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=8'h00, out_sel=0 and in_ready=0 before the next clk edge.
REQ-029 Single request: in_valid=8'b0000_0100, ch2 data=8'hA5, out_ready=1 -> in_ready=8'b0000_0100 that cycle; next cycle out_valid=1, out_data=8'hA5, out_sel=2.
REQ-030 Round-robin fairness: MODE=0, in_valid=8'hFF, out_ready=1 for 10 cycles -> out_sel sequence 0,1,2,3,4,5,6,7,0,1.
REQ-031 Back-pressure: out_valid=1 with out_sel=3, out_ready=0 for 3 cycles -> out_data and out_sel stable and in_ready=0; after out_ready=1 with all channels valid -> next out_sel=4.
REQ-032 Fixed priority: MODE=1, in_valid=8'b0010_0001 -> out_sel=0 every cycle; clear bit 0 -> out_sel=5.
REQ-033 Non-power-of-two wrap: N=5, in_valid=5'b10001 -> out_sel alternates 0,4,0,4; no grant index is ever 5, 6 or 7.
